// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue (ifetch_queue and ifq_fifo).
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifq_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of fetched {instruction, PC+4} pairs; clear wins over push and pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int          CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  ifq_entry_t    din_i,
    output ifq_entry_t    head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns fetch PC, talks req/ack to imem, queues words for IF/ID.
// Optional macro IFQ_BYPASS_EN: an ack into an empty queue is presented in the same cycle.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifq_valid,
    input  logic        ifq_ready,
    output logic [31:0] ifq_ins,
    output logic [31:0] ifq_pc4,
    output ifq_state_e  dbg_state_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_d;
    logic [31:0]   addr_out_d;
    logic          take_d;
    logic [31:0]   ret_pc4;
    ifq_entry_t    ret_entry;
    ifq_entry_t    fifo_head;
    ifq_entry_t    head_mux;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass;

    assign ret_pc4   = addr_q + PC_STEP;
    assign ret_entry = '{ins: imem_rdata, pc4: ret_pc4};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // take_d marks a returned word that belongs to the current fetch stream.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        addr_out_d = fetch_pc_q;
        take_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_en) begin
                    fetch_pc_d = redirect_pc;
                end else if (fifo_count < CW'(DEPTH)) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                req_d      = 1'b1;
                addr_out_d = addr_q;
                if (redirect_en) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    take_d     = 1'b1;
                    fetch_pc_d = ret_pc4;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                req_d      = 1'b1;
                addr_out_d = addr_q;
                if (redirect_en) fetch_pc_d = redirect_pc;
                if (imem_ack)    state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IFQ_BYPASS_EN
    assign bypass = take_d && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // Toward IF/ID: a head transfers on any cycle where ifq_valid && ifq_ready, and a
    // redirect in the same cycle cancels that transfer along with everything queued.
    assign fifo_pop  = ifq_ready && !fifo_empty && !redirect_en;
    assign fifo_push = take_d && !(bypass && ifq_ready);
    assign head_mux  = bypass ? ret_entry : fifo_head;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (redirect_en),
        .din_i   (ret_entry),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Reset must pull the request down at once, not at the next edge.
    assign imem_req    = req_d && !RST;
    assign imem_addr   = addr_out_d;
    assign ifq_valid   = !fifo_empty || bypass;
    assign ifq_ins     = ifq_valid ? head_mux.ins : 32'h0;
    assign ifq_pc4     = ifq_valid ? head_mux.pc4 : 32'h0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: queue-based fetch model checked every cycle plus literal pins.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] XK    = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifq_valid;
    logic        ifq_ready;
    logic [31:0] ifq_ins;
    logic [31:0] ifq_pc4;
    ifq_state_e  dbg_state;

    always #5 CLK = ~CLK;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ifq_valid   (ifq_valid),
        .ifq_ready   (ifq_ready),
        .ifq_ins     (ifq_ins),
        .ifq_pc4     (ifq_pc4),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Model: queued words as {ins, pc4}, next fetch address, one outstanding request.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_drop;

    // Memory stub and observation logs.
    int          mem_lat   = 1;
    bit          mem_on    = 1'b1;
    bit          force_ack = 1'b0;
    int          req_cnt   = 0;
    logic [31:0] ack_log[$];
    logic [31:0] pop_pc4[$];
    logic [31:0] pop_ins[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc   = RPC;
        m_addr = RPC;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic compare_outputs();
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
        if (RST) begin
            e_req = 1'b0; e_addr = RPC; e_valid = 1'b0; e_ins = '0; e_pc4 = '0;
        end else begin
            e_req   = m_out || (!redirect_en && exp_q.size() < DEPTH);
            e_addr  = m_out ? m_addr : m_pc;
            e_valid = exp_q.size() > 0;
            {e_ins, e_pc4} = e_valid ? exp_q[0] : 64'h0;
`ifdef IFQ_BYPASS_EN
            if (!e_valid && m_out && !m_drop && imem_ack && !redirect_en) begin
                e_valid = 1'b1; e_ins = imem_rdata; e_pc4 = m_addr + 32'd4;
            end
`endif
        end
        check("imem_req", imem_req, e_req);
        check("imem_addr", imem_addr, e_addr);
        check("ifq_valid", ifq_valid, e_valid);
        check("ifq_ins", ifq_ins, e_ins);
        check("ifq_pc4", ifq_pc4, e_pc4);
    endtask

    task automatic model_step();
        int  size0;
        bit  issue;
        if (RST) begin
            model_reset();
            return;
        end
        size0 = exp_q.size();
        if (redirect_en) begin
            exp_q.delete();
            m_pc = redirect_pc;
            if (m_out) begin
                if (imem_ack) begin m_out = 1'b0; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end
        end else begin
            issue = !m_out && (size0 < DEPTH);
            if (size0 > 0 && ifq_ready) void'(exp_q.pop_front());
            if (m_out && imem_ack) begin
                if (!m_drop) begin
                    m_pc = m_addr + 32'd4;
`ifdef IFQ_BYPASS_EN
                    if (!(size0 == 0 && ifq_ready)) exp_q.push_back({imem_rdata, m_pc});
`else
                    exp_q.push_back({imem_rdata, m_pc});
`endif
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (issue) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    // One clock: drive inputs just after posedge, check and advance the model at negedge.
    task automatic cycle(input bit red = 1'b0, input logic [31:0] rpc = 32'h0);
        redirect_en = red;
        redirect_pc = rpc;
        #1;
        imem_ack   = force_ack || (mem_on && imem_req && req_cnt >= mem_lat);
        imem_rdata = imem_ack ? (imem_addr ^ XK) : 32'h0;
        @(negedge CLK);
        if (!RST && !force_ack && imem_ack && imem_req) ack_log.push_back(imem_addr);
        if (!RST && ifq_valid && ifq_ready && !redirect_en) begin
            pop_pc4.push_back(ifq_pc4);
            pop_ins.push_back(ifq_ins);
        end
        compare_outputs();
        model_step();
        if (RST || imem_ack || !imem_req) req_cnt = 0;
        else req_cnt++;
        @(posedge CLK);
        #1;
        redirect_en = 1'b0;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        pop_pc4.delete();
        pop_ins.delete();
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        imem_ack = 1'b0;
        force_ack = 1'b0;
        mem_on = 1'b1;
        req_cnt = 0;
        model_reset();
        repeat (2) cycle();
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", ifq_valid, 1'b0);
        check("rst_ins", ifq_ins, 32'h0);
        check("rst_pc4", ifq_pc4, 32'h0);
        check("rst_state", dbg_state, IDLE);
        RST = 1'b0;
        clear_logs();
    endtask

    initial begin
        int n;
        RST = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; ifq_ready = 1'b0;

        // Streaming with 1-cycle memory.
        apply_reset();
        mem_lat = 1; ifq_ready = 1'b1;
        repeat (12) cycle();
        check("t1_addr0", ack_log[0], 32'h0);
        check("t1_addr1", ack_log[1], 32'h4);
        check("t1_addr2", ack_log[2], 32'h8);
        check("t1_pc4_0", pop_pc4[0], 32'h4);
        check("t1_pc4_1", pop_pc4[1], 32'h8);
        check("t1_pc4_2", pop_pc4[2], 32'hC);
        check("t1_ins0", pop_ins[0], 32'hA5A5_0000);

        // Stall fills the queue, then drains and resumes.
        apply_reset();
        mem_lat = 1; ifq_ready = 1'b0;
        repeat (20) cycle();
        check("t2_nreq", ack_log.size(), 4);
        check("t2_last", ack_log[3], 32'hC);
        check("t2_req_off", imem_req, 1'b0);
        check("t2_valid", ifq_valid, 1'b1);
        clear_logs();
        ifq_ready = 1'b1;
        repeat (12) cycle();
        check("t2_drain0", pop_pc4[0], 32'h4);
        check("t2_drain3", pop_pc4[3], 32'h10);
        check("t2_resume", ack_log[0], 32'h10);

        // Redirect while waiting on addr 8 with a 3-cycle memory.
        apply_reset();
        mem_lat = 3; ifq_ready = 1'b0;
        n = 0;
        while (!(req_cnt == 1 && imem_addr == 32'h8) && n < 200) begin cycle(); n++; end
        check("t3_reach", n < 200, 1'b1);
        cycle(1'b1, 32'h100);
        check("t3_empty", ifq_valid, 1'b0);
        ifq_ready = 1'b1;
        repeat (20) cycle();
        check("t3_drop_ack", ack_log[2], 32'h8);
        check("t3_next", ack_log[3], 32'h100);
        check("t3_pop", pop_pc4[0], 32'h104);

        // Redirect, ack and pop all in one cycle.
        apply_reset();
        mem_lat = 1; ifq_ready = 1'b0;
        n = 0;
        while (!(ack_log.size() >= 2 && req_cnt == 1) && n < 200) begin cycle(); n++; end
        check("t4_reach", n < 200, 1'b1);
        ifq_ready = 1'b1;
        cycle(1'b1, 32'h200);
        check("t4_empty", ifq_valid, 1'b0);
        repeat (10) cycle();
        check("t4_acked8", ack_log[2], 32'h8);
        check("t4_next", ack_log[3], 32'h200);
        check("t4_pop", pop_pc4[0], 32'h204);
        check("t4_ins", pop_ins[0], 32'hA5A5_0200);

        // PC wrap at the top of the address space.
        apply_reset();
        mem_lat = 1; ifq_ready = 1'b1;
        cycle(1'b1, 32'hFFFF_FFFC);
        repeat (10) cycle();
        check("t5_addr", ack_log[0], 32'hFFFF_FFFC);
        check("t5_pc4", pop_pc4[0], 32'h0);
        check("t5_ins", pop_ins[0], 32'h5A5A_FFFC);
        check("t5_wrap", ack_log[1], 32'h0);

        // Asynchronous reset in WAIT, then a stale ack.
        apply_reset();
        mem_lat = 3; ifq_ready = 1'b1;
        repeat (4) cycle();
        n = 0;
        while (req_cnt != 1 && n < 200) begin cycle(); n++; end
        check("t6_reach", n < 200, 1'b1);
        check("t6_pre_req", imem_req, 1'b1);
        #2 RST = 1'b1;
        #1;
        check("t6_req_drop", imem_req, 1'b0);
        check("t6_state", dbg_state, IDLE);
        imem_ack = 1'b0;
        req_cnt = 0;
        model_reset();
        cycle();
        RST = 1'b0;
        clear_logs();
        mem_on = 1'b0; force_ack = 1'b1;
        cycle();
        force_ack = 1'b0; mem_on = 1'b1;
        check("t6_stale", ifq_valid, 1'b0);
        repeat (10) cycle();
        check("t6_addr", ack_log[0], RPC);
        check("t6_pc4", pop_pc4[0], RPC + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
